pipe_out_gen: RTL and testbench

Pattern source for the host Pipe Out path of the pipe throughput test. Produces a deterministic 32-bit word stream (fixed, counter, LFSR or walking-one) on each host read strobe and paces availability through a throttled virtual FIFO so the host sees realistic block-ready stalls. It sits directly behind the block-throttled Pipe Out endpoint and is the transmit-side counterpart of the Pipe In checker.

---
 rtl/pipe_test_pkg.sv | 53 +++++
 rtl/pipe_out_gen_if.sv | 22 ++
 rtl/pipe_out_pattern.sv | 38 +++
 rtl/pipe_out_gen.sv | 123 ++++++++++++
 tb/tb_pipe_out_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_test_pkg.sv
// rtl/pipe_test_pkg.sv - shared encodings, constants and word-generation helpers for the pipe throughput test
package pipe_test_pkg;

  // Pattern mode encodings as driven on the pattern select input.
  typedef enum logic [1:0] {
    PAT_FIXED = 2'b00,
    PAT_COUNT = 2'b01,
    PAT_LFSR  = 2'b10,
    PAT_WALK  = 2'b11
  } pat_mode_e;

  // Feedback taps for the right-shifting Galois LFSR.
  localparam logic [31:0] LFSR_MASK = 32'hE000_0200;

  // First word of the counter and walking-one streams, and the LFSR
  // substitute seed when the programmed seed is zero (a zero LFSR locks up).
  localparam logic [31:0] PAT_SEED = 32'h0000_0001;

  // Virtual FIFO depth; the level register needs one extra bit to hold it.
  localparam int VFIFO_MAX = 65536;
  localparam int LEVEL_W   = 17;

  // Saturation point of the underrun counter.
  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Word presented straight out of reset for a given mode.
  function automatic logic [31:0] pat_first_word(pat_mode_e mode, logic [31:0] fixed_word);
    logic [31:0] w;
    w = PAT_SEED;
    case (mode)
      PAT_FIXED: w = fixed_word;
      PAT_LFSR:  w = (fixed_word == 32'h0) ? PAT_SEED : fixed_word;
      default:   w = PAT_SEED;
    endcase
    return w;
  endfunction

  // Word that follows cur once cur has been consumed by a read.
  function automatic logic [31:0] pat_next_word(pat_mode_e mode, logic [31:0] cur,
                                                logic [31:0] fixed_word);
    logic [31:0] w;
    w = cur;
    case (mode)
      PAT_FIXED: w = fixed_word;
      PAT_COUNT: w = cur + 32'd1;
      PAT_LFSR:  w = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_MASK : 32'h0);
      PAT_WALK:  w = {cur[30:0], cur[31]};
      default:   w = cur;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pipe_out_gen_if.sv
// rtl/pipe_out_gen_if.sv - Pipe Out endpoint handshake: read strobe, data word and block-ready
interface pipe_out_gen_if;

  logic        pipe_out_read;
  logic [31:0] pipe_out_data;
  logic        pipe_out_ready;

  // Endpoint side: issues reads, observes data and block-ready.
  modport master (
    output pipe_out_read,
    input  pipe_out_data,
    input  pipe_out_ready
  );

  // Generator side: answers reads with data and paces block-ready.
  modport slave (
    input  pipe_out_read,
    output pipe_out_data,
    output pipe_out_ready
  );

endinterface

// File: rtl/pipe_out_pattern.sv
// rtl/pipe_out_pattern.sv - mode-latched 32-bit word generator advanced once per consumed word
module pipe_out_pattern
  import pipe_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pattern_i,
  input  logic [31:0] fixed_pattern_i,
  input  logic        advance_i,
  output logic [31:0] data_o
);

  pat_mode_e   mode_q;
  pat_mode_e   mode_d;
  logic [31:0] data_q;
  logic [31:0] data_d;

  // Mode is only captured while reset is held; data steps to the next word per advance.
  always_comb begin
    mode_d = mode_q;
    data_d = data_q;
    if (reset) begin
      mode_d = pat_mode_e'(pattern_i);
      data_d = pat_first_word(pat_mode_e'(pattern_i), fixed_pattern_i);
    end else if (advance_i) begin
      data_d = pat_next_word(mode_q, data_q, fixed_pattern_i);
    end
  end

  // Mode and current-word registers.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/pipe_out_gen.sv
// rtl/pipe_out_gen.sv - Pipe Out pattern source with throttled virtual FIFO; PIPE_OUT_GEN_UNDERRUN_EN enables underrun counter
module pipe_out_gen
  import pipe_test_pkg::*;
#(
  parameter int BLOCK_WORDS = 256
)
(
  input  logic                 clk,
  input  logic                 reset,
  pipe_out_gen_if.slave        pipe_if,
  input  logic                 throttle_set_i,
  input  logic [31:0]          throttle_val_i,
  input  logic [31:0]          fixed_pattern_i,
  input  logic [1:0]           pattern_i,
  output logic [31:0]          word_count_o,
  output logic [15:0]          underrun_count_o
);

  localparam logic [LEVEL_W-1:0] READY_LEVEL = LEVEL_W'(BLOCK_WORDS);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(VFIFO_MAX);

  logic               rd;
  logic               fill;
  logic               drain;
  logic               level_empty;

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic [31:0]        throttle_q;
  logic [31:0]        throttle_d;
  logic               ready_q;
  logic               ready_d;
  logic [31:0]        word_count_q;
  logic [31:0]        word_count_d;

  assign rd          = pipe_if.pipe_out_read;
  assign level_empty = (level_q == '0);

  // Virtual FIFO: a throttle bit adds a word, a read removes one; both cancel.
  always_comb begin
    fill    = throttle_q[0] && (level_q != LEVEL_MAX);
    drain   = rd && !level_empty;
    level_d = level_q;
    if (fill && !drain) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (drain && !fill) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  // Throttle rotates each cycle; a load replaces the rotation, so the fill
  // decision above still sees the old bit 0 in the load cycle.
  always_comb begin
    throttle_d = {throttle_q[0], throttle_q[31:1]};
    if (throttle_set_i) begin
      throttle_d = throttle_val_i;
    end
  end

  // Ready follows the registered level, and word_count counts every read, underruns included.
  always_comb begin
    ready_d      = (level_q >= READY_LEVEL);
    word_count_d = word_count_q;
    if (rd) begin
      word_count_d = word_count_q + 32'd1;
    end
  end

  // Level, throttle, ready and word-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q      <= '0;
      throttle_q   <= throttle_val_i;
      ready_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      level_q      <= level_d;
      throttle_q   <= throttle_d;
      ready_q      <= ready_d;
      word_count_q <= word_count_d;
    end
  end

`ifdef PIPE_OUT_GEN_UNDERRUN_EN
  logic [15:0] underrun_q;
  logic [15:0] underrun_d;

  // A read against an empty level is an underrun; the count sticks at its maximum.
  always_comb begin
    underrun_d = underrun_q;
    if (rd && level_empty && (underrun_q != UNDERRUN_MAX)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= '0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_count_o = underrun_q;
`else
  assign underrun_count_o = '0;
`endif

  // Every read consumes the presented word, even when the level is empty.
  pipe_out_pattern u_pattern (
    .clk             (clk),
    .reset           (reset),
    .pattern_i       (pattern_i),
    .fixed_pattern_i (fixed_pattern_i),
    .advance_i       (rd),
    .data_o          (pipe_if.pipe_out_data)
  );

  assign pipe_if.pipe_out_ready = ready_q;
  assign word_count_o           = word_count_q;

endmodule

// File: tb/tb_pipe_out_gen.sv
// tb/tb_pipe_out_gen.sv - scoreboard bench for pipe_out_gen (thresholds 256 and 100)
module tb_pipe_out_gen;

`ifdef PIPE_OUT_GEN_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        tset;
  logic [31:0] thr_val;
  logic [31:0] fixed;
  logic [1:0]  pat;
  logic [31:0] wc_a, wc_b;
  logic [15:0] ur_a, ur_b;

  pipe_out_gen_if if_a ();
  pipe_out_gen_if if_b ();
  assign if_a.pipe_out_read = rd;
  assign if_b.pipe_out_read = rd;

  pipe_out_gen #(.BLOCK_WORDS(256)) dut (
    .clk(clk), .reset(reset), .pipe_if(if_a), .throttle_set_i(tset), .throttle_val_i(thr_val),
    .fixed_pattern_i(fixed), .pattern_i(pat), .word_count_o(wc_a), .underrun_count_o(ur_a));

  pipe_out_gen #(.BLOCK_WORDS(100)) dut_b (
    .clk(clk), .reset(reset), .pipe_if(if_b), .throttle_set_i(tset), .throttle_val_i(thr_val),
    .fixed_pattern_i(fixed), .pattern_i(pat), .word_count_o(wc_b), .underrun_count_o(ur_b));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  b_mode;
  logic [31:0] b_fixed;

  // Reference model of level, throttle, ready and underruns.
  int          m_lvl;
  int          m_ur;
  logic [31:0] m_thr;
  logic        m_r256, m_r100;

  always @(posedge clk) begin
    if (reset) begin
      m_lvl <= 0; m_ur <= 0; m_thr <= thr_val; m_r256 <= 1'b0; m_r100 <= 1'b0;
    end else begin
      m_lvl  <= m_lvl + ((m_thr[0] && m_lvl < 65536) ? 1 : 0) - ((rd && m_lvl > 0) ? 1 : 0);
      m_r256 <= (m_lvl >= 256);
      m_r100 <= (m_lvl >= 100);
      m_thr  <= tset ? thr_val : {m_thr[0], m_thr[31:1]};
      if (rd && m_lvl == 0 && m_ur < 65535) m_ur <= m_ur + 1;
    end
  end

  function automatic logic [31:0] b_first(logic [1:0] m, logic [31:0] f);
    if (m == 2'b00) return f;
    if (m == 2'b10) return (f == 32'h0) ? 32'h1 : f;
    return 32'h1;
  endfunction

  function automatic logic [31:0] b_next(logic [1:0] m, logic [31:0] w, logic [31:0] f);
    case (m)
      2'b00:   return f;
      2'b01:   return w + 32'd1;
      2'b10:   return (w >> 1) ^ (w[0] ? 32'hE000_0200 : 32'h0);
      default: return {w[30:0], w[31]};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [31:0] f, input logic [31:0] tv);
    @(negedge clk);
    reset = 1'b1; rd = 1'b0; tset = 1'b0; pat = m; fixed = f; thr_val = tv;
    tick(1);
    reset = 1'b0;
    b_mode = m; b_fixed = f;
    exp_q.delete();
    exp_q.push_back(b_first(m, f));
  endtask

  task automatic test_reset();
    do_reset(2'b01, 32'h1234_5678, 32'hFFFF_FFFF);
    total++; if (if_a.pipe_out_data !== 32'h1) begin bad++; $display("FAIL reset_data: got %h want %h", if_a.pipe_out_data, 32'h1); end
    total++; if (if_a.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", if_a.pipe_out_ready); end
    total++; if (wc_a !== 32'h0) begin bad++; $display("FAIL reset_wc: got %0d want 0", wc_a); end
    total++; if (ur_a !== 16'h0) begin bad++; $display("FAIL reset_ur: got %0d want 0", ur_a); end
    total++; if (if_b.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_b: got %b want 0", if_b.pipe_out_ready); end
  endtask

  task automatic test_fixed();
    logic [31:0] e;
    do_reset(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL fixed_word%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    rd = 1'b0;
    total++; if (if_a.pipe_out_data !== exp_q[0]) begin bad++; $display("FAIL fixed_hold: got %h want %h", if_a.pipe_out_data, exp_q[0]); end
  endtask

  task automatic test_fill();
    do_reset(2'b01, 32'h0, 32'hFFFF_FFFF);
    tick(256);
    total++; if (if_a.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_256: got %b want 0", if_a.pipe_out_ready); end
    tick(1);
    total++; if (if_a.pipe_out_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_257: got %b want 1", if_a.pipe_out_ready); end
    total++; if (if_a.pipe_out_data !== 32'h1) begin bad++; $display("FAIL fill_data: got %h want %h", if_a.pipe_out_data, 32'h1); end
  endtask

  task automatic test_burst();
    logic [31:0] e;
    tset = 1'b1; thr_val = 32'h0; tick(1); tset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL burst_word%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      total++; if (if_a.pipe_out_ready !== m_r256) begin bad++; $display("FAIL burst_ready%0d: got %b want %b", i, if_a.pipe_out_ready, m_r256); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    rd = 1'b0;
    total++; if (if_a.pipe_out_data !== 32'h12D) begin bad++; $display("FAIL burst_next: got %h want %h", if_a.pipe_out_data, 32'h12D); end
    total++; if (wc_a !== 32'd300) begin bad++; $display("FAIL burst_wc: got %0d want 300", wc_a); end
    total++; if (if_a.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL burst_ready_end: got %b want 0", if_a.pipe_out_ready); end
    total++; if (ur_a !== (UR_EN ? 16'(m_ur) : 16'h0)) begin bad++; $display("FAIL burst_ur: got %0d want %0d", ur_a, UR_EN ? m_ur : 0); end
  endtask

  task automatic test_throttle();
    logic [31:0] e;
    do_reset(2'b01, 32'h0, 32'h0000_0001);
    tick(3169);
    total++; if (if_b.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL thr_ready_b_3169: got %b want 0", if_b.pipe_out_ready); end
    tick(1);
    total++; if (if_b.pipe_out_ready !== 1'b1) begin bad++; $display("FAIL thr_ready_b_3170: got %b want 1", if_b.pipe_out_ready); end
    tick(29);
    tset = 1'b1; thr_val = 32'hAAAA_AAAA; tick(1); tset = 1'b0;
    tick(64);
    tset = 1'b1; thr_val = 32'h0; tick(1); tset = 1'b0;
    total++; if (if_a.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL thr_ready_a: got %b want 0", if_a.pipe_out_ready); end
    for (int i = 0; i < 33; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL thr_word%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    rd = 1'b0;
    total++; if (if_b.pipe_out_ready !== 1'b1) begin bad++; $display("FAIL thr_level_132: got %b want 1", if_b.pipe_out_ready); end
    tick(1);
    total++; if (if_b.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL thr_level_99: got %b want 0", if_b.pipe_out_ready); end
    total++; if (ur_a !== 16'h0) begin bad++; $display("FAIL thr_ur: got %0d want 0", ur_a); end
  endtask

  task automatic test_lfsr();
    logic [31:0] e;
    do_reset(2'b10, 32'h0, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL lfsr_word%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    rd = 1'b0;
    total++; if (if_a.pipe_out_data !== 32'h7000_0100) begin bad++; $display("FAIL lfsr_third: got %h want %h", if_a.pipe_out_data, 32'h7000_0100); end
  endtask

  task automatic test_underrun();
    logic [31:0] e;
    do_reset(2'b11, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL walk_word%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    rd = 1'b0;
    total++; if (ur_a !== (UR_EN ? 16'd5 : 16'd0)) begin bad++; $display("FAIL ur_count: got %0d want %0d", ur_a, UR_EN ? 5 : 0); end
    total++; if (wc_a !== 32'd5) begin bad++; $display("FAIL ur_wc: got %0d want 5", wc_a); end
    total++; if (if_a.pipe_out_data !== 32'h20) begin bad++; $display("FAIL ur_data: got %h want %h", if_a.pipe_out_data, 32'h20); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] e;
    do_reset(2'b01, 32'h0, 32'hFFFF_FFFF);
    pat = 2'b10;
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL mid_word%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    reset = 1'b1; pat = 2'b11; tick(1);
    reset = 1'b0; rd = 1'b0;
    b_mode = 2'b11; exp_q.delete(); exp_q.push_back(32'h1);
    total++; if (if_a.pipe_out_data !== 32'h1) begin bad++; $display("FAIL mid_data: got %h want %h", if_a.pipe_out_data, 32'h1); end
    total++; if (if_a.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", if_a.pipe_out_ready); end
    total++; if (if_b.pipe_out_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_b: got %b want 0", if_b.pipe_out_ready); end
    total++; if (wc_a !== 32'h0) begin bad++; $display("FAIL mid_wc: got %0d want 0", wc_a); end
    total++; if (ur_a !== 16'h0) begin bad++; $display("FAIL mid_ur: got %0d want 0", ur_a); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total++; if (if_a.pipe_out_data !== e) begin bad++; $display("FAIL mid_walk%0d: got %h want %h", i, if_a.pipe_out_data, e); end
      rd = 1'b1; exp_q.push_back(b_next(b_mode, e, b_fixed)); tick(1);
    end
    rd = 1'b0;
    total++; if (if_a.pipe_out_data !== 32'h4) begin bad++; $display("FAIL mid_relatch: got %h want %h", if_a.pipe_out_data, 32'h4); end
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; tset = 1'b0; thr_val = 32'h0; fixed = 32'h0; pat = 2'b00;
    test_reset();
    test_fixed();
    test_fill();
    test_burst();
    test_throttle();
    test_lfsr();
    test_underrun();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
